// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform capture path.
package wave_pkg;

    typedef enum logic [1:0] {
        WC_ARMED  = 2'd0,
        WC_ACTIVE = 2'd1,
        WC_WAIT   = 2'd2
    } wc_state_e;

    localparam int NUM_SAMPLES = 256;
    localparam int RAM_ADDR_W  = 9;
    localparam int SAMPLE_W    = 16;
    localparam int DISP_W      = 8;

    // Signed sample to offset-binary display byte (top 8 bits, sign flipped).
    function automatic logic [DISP_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-DISP_W]};
    endfunction

endpackage

// File: rtl/zero_cross_detect.sv
// Positive zero-crossing detector: remembers the sign of the last accepted
// sample and pulses when a negative sample is followed by a non-negative one.
module zero_cross_detect (
    input  logic clk,
    input  logic rst,
    input  logic strobe_i,
    input  logic sign_i,
    output logic cross_o
);

    // Only the sign of the previous sample matters for the crossing test.
    logic prev_neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_neg_q <= 1'b0;
        end else if (strobe_i) begin
            prev_neg_q <= sign_i;
        end
    end

    assign cross_o = strobe_i & prev_neg_q & ~sign_i;

endmodule

// File: rtl/wave_capture_ctrl.sv
// Ping-pong capture sequencer: arms on a positive zero crossing, writes 256
// decimated display samples into the idle RAM half, flips halves on vblank.
module wave_capture_ctrl
    import wave_pkg::*;
#(
    parameter int DECIM   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic                  wave_display_idle,
    output logic [RAM_ADDR_W-1:0] write_address,
    output logic                  write_enable,
    output logic [DISP_W-1:0]     write_sample,
    output logic                  read_index,
    output logic [1:0]            capture_state
);

    localparam logic [15:0] DECIM_FIRST = (DECIM == 1) ? 16'd0 : 16'd1;
    localparam logic [15:0] DECIM_LAST  = 16'(DECIM - 1);
    localparam logic [7:0]  INDEX_LAST  = 8'(NUM_SAMPLES - 1);

    wc_state_e         state_q;
    logic              read_index_q;
    logic              we_q;
    logic [RAM_ADDR_W-1:0] addr_q;
    logic [DISP_W-1:0] sample_q;
    logic [7:0]        index_q;
    logic [15:0]       decim_q;
    logic [31:0]       timeout_q;

    logic crossing;
    logic timed_out;
    logic trigger;
    logic unused_low_bits;

    zero_cross_detect u_zcd (
        .clk      (clk),
        .rst      (reset),
        .strobe_i (new_sample_ready),
        .sign_i   (new_sample_in[SAMPLE_W-1]),
        .cross_o  (crossing)
    );

    assign timed_out       = (TIMEOUT != 0) && (timeout_q == 32'(TIMEOUT - 1));
    assign trigger         = crossing || (new_sample_ready && timed_out);
    assign unused_low_bits = ^new_sample_in[SAMPLE_W-DISP_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= WC_ARMED;
            read_index_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            sample_q     <= '0;
            index_q      <= '0;
            decim_q      <= '0;
            timeout_q    <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                WC_ARMED: begin
                    if (trigger) begin
                        state_q   <= WC_ACTIVE;
                        we_q      <= 1'b1;
                        addr_q    <= {~read_index_q, index_q};
                        sample_q  <= to_offset_binary(new_sample_in);
                        index_q   <= index_q + 8'd1;
                        decim_q   <= DECIM_FIRST;
                        timeout_q <= '0;
                    end else if (new_sample_ready) begin
                        timeout_q <= timeout_q + 32'd1;
                    end
                end
                WC_ACTIVE: begin
                    if (new_sample_ready) begin
                        if (decim_q == '0) begin
                            we_q     <= 1'b1;
                            addr_q   <= {~read_index_q, index_q};
                            sample_q <= to_offset_binary(new_sample_in);
                            index_q  <= index_q + 8'd1;
                            if (index_q == INDEX_LAST) begin
                                state_q <= WC_WAIT;
                            end
                        end
                        decim_q <= (decim_q == DECIM_LAST) ? '0 : decim_q + 16'd1;
                    end
                end
                WC_WAIT: begin
                    // Hold the flip until the final write has left the RAM port.
                    if (wave_display_idle && !we_q) begin
                        read_index_q <= ~read_index_q;
                        state_q      <= WC_ARMED;
                    end
                end
                default: state_q <= WC_ARMED;
            endcase
        end
    end

    assign write_address = addr_q;
    assign write_enable  = we_q;
    assign write_sample  = sample_q;
    assign read_index    = read_index_q;
    assign capture_state = state_q;

endmodule
